flash_fetch_unit: RTL and testbench
===================================

FLASH_FETCH_UNIT -- requirements
Module: flash_fetch_unit

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving the SCK half-period in clk cycles (legal range 1..255).
REQ-002 The block SHALL have parameter BASE_ADDR, default 24'h000000, giving the byte offset of instruction word 0 in the SPI flash.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-005 The block SHALL have port pc_addr, input, 12, the word address of the instruction to fetch.
REQ-006 The block SHALL have port fetch_req, input, 1, a level request from the core to fetch pc_addr.
REQ-007 The block SHALL have port flash_data, output, 16, the fetched instruction word.
REQ-008 The block SHALL have port data_valid, output, 1, a one-cycle pulse meaning flash_data is new; it drives the core's clk_valid.
REQ-009 The block SHALL have port busy, output, 1, high from request acceptance until the data_valid cycle, inclusive.
REQ-010 The block SHALL have ports spi_cs_n (output, 1, active low), spi_sck (output, 1), spi_mosi (output, 1) and spi_miso (input, 1), the SPI flash master pins.

Function
REQ-011 The state machine SHALL have the states IDLE, CMD, ADDR, DATA, DONE and GAP.
REQ-012 In IDLE, with fetch_req=1, the block SHALL capture pc_addr, set busy, drive spi_cs_n low on the next cycle and enter CMD.
REQ-013 CMD SHALL shift out the 8-bit read opcode 8'h03, MSB first.
REQ-014 ADDR SHALL shift out the 24-bit byte address (BASE_ADDR + {pc_addr,1'b0}) mod 2^24, MSB first; the address wraps silently at 24 bits.
REQ-015 DATA SHALL shift in 16 bits, MSB first; the first byte received is flash_data[15:8].
REQ-016 The SPI interface SHALL be mode 0: SCK idles low, MOSI changes only while SCK is low, and MISO is sampled on the SCK rising edge.
REQ-017 Each bit SHALL occupy exactly 2*CLK_DIV clk cycles.
REQ-018 DONE SHALL update flash_data, pulse data_valid for exactly one cycle, drive spi_cs_n high, and go to GAP.
REQ-019 data_valid SHALL rise exactly 1 + 96*CLK_DIV cycles after the cycle in which the request is accepted (193 cycles for CLK_DIV=2).
REQ-020 GAP SHALL hold spi_cs_n high for at least 2 cycles, then return to IDLE; a fetch_req held high during GAP is accepted on return to IDLE.
REQ-021 Changes on pc_addr after acceptance SHALL be ignored until the next acceptance.
REQ-022 Deasserting fetch_req mid-transaction SHALL NOT abort it; the transaction completes and data_valid still pulses.
REQ-023 flash_data SHALL hold its value between DONE cycles.
REQ-024 spi_mosi SHALL be 0 outside CMD and ADDR.

Reset
REQ-025 While rst=1, the block SHALL force state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, flash_data=16'h0000, data_valid=0 and busy=0.
REQ-026 rst asserted mid-transaction SHALL abort the transaction at the next clk edge, with no data_valid pulse and no flash_data update.
REQ-027 The first request SHALL be accepted on the first cycle with rst=0.

Configuration
REQ-028 With macro FETCH_CACHE_EN defined, the block SHALL keep a single-entry cache (a 12-bit tag, a 16-bit word and a valid bit) written at every DONE.
REQ-029 With FETCH_CACHE_EN defined, an accepted request whose pc_addr equals a valid tag SHALL pulse data_valid on the next cycle, with that cached word on flash_data and no SPI activity (spi_cs_n stays 1).
REQ-030 With FETCH_CACHE_EN defined, reset SHALL clear the cache valid bit.
REQ-031 Without FETCH_CACHE_EN, no cache logic SHALL exist and every request SHALL run a full SPI transaction.

Verification
REQ-032 Reset scenario: hold rst for 3 cycles during an active transaction -> spi_cs_n=1, spi_sck=0, flash_data=0, and no data_valid pulse.
REQ-033 Basic read: CLK_DIV=2, pc_addr=12'h005, flash model holding bytes 0x0A=8'hA5 and 0x0B=8'h3C -> MOSI carries 03 00 00 0A, flash_data=16'hA53C, and data_valid arrives 193 cycles after acceptance.
REQ-034 Address wrap: BASE_ADDR=24'hFFFFF0, pc_addr=12'h010 -> transmitted address is 24'h000010.
REQ-035 Request glitch: fetch_req dropped and pc_addr changed to 12'h7FF after acceptance of 12'h001 -> address 12'h001 is fetched, one data_valid pulse occurs, and no second transaction starts.
REQ-036 Back-to-back: fetch_req held high for requests 12'h000 then 12'h001 -> spi_cs_n is high for at least 2 cycles between the transactions, and two data_valid pulses occur.
REQ-037 Cache (FETCH_CACHE_EN defined): repeat a request to 12'h020 -> data_valid one cycle after acceptance with the same word and no SPI toggling; after rst, the same request runs a full SPI transaction.

Source files
------------

// File: rtl/flash_fetch_unit.sv
// SPI flash instruction fetch unit: READ (0x03), 24-bit address, 16-bit word.
// Optional single-entry fetch cache enabled with macro FETCH_CACHE_EN.
module flash_fetch_unit #(
    parameter int          CLK_DIV   = 2,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pc_addr,
    input  logic        fetch_req,
    output logic [15:0] flash_data,
    output logic        data_valid,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] READ_OP  = 8'h03;

    state_t      state, state_next;
    logic [30:0] tx, tx_next;
    logic [15:0] rx, rx_next;
    logic [7:0]  div_cnt, div_next;
    logic [5:0]  bit_cnt, bit_next;
    logic        gap_cnt, gap_next;
    logic        sck_next, cs_n_next, mosi_next;
    logic        valid_next, busy_next;
    logic [15:0] data_next;
    logic [23:0] byte_addr;
    logic        hit;
    logic [15:0] hit_word;

`ifdef FETCH_CACHE_EN
    logic [11:0] req_addr, addr_next;
    logic [11:0] cache_tag;
    logic [15:0] cache_word;
    logic        cache_valid;

    assign hit      = cache_valid && (cache_tag == pc_addr);
    assign hit_word = cache_word;
`else
    assign hit      = 1'b0;
    assign hit_word = 16'h0000;
`endif

    // byte address wraps silently at 24 bits
    assign byte_addr = BASE_ADDR + {11'd0, pc_addr, 1'b0};

    // next-state and next-output logic for the fetch sequencer
    always_comb begin
        state_next = state;
        tx_next    = tx;
        rx_next    = rx;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        gap_next   = gap_cnt;
        sck_next   = spi_sck;
        cs_n_next  = spi_cs_n;
        mosi_next  = spi_mosi;
        valid_next = 1'b0;
        busy_next  = busy;
        data_next  = flash_data;
`ifdef FETCH_CACHE_EN
        addr_next  = req_addr;
`endif
        unique case (state)
            IDLE: begin
                if (fetch_req) begin
                    busy_next = 1'b1;
`ifdef FETCH_CACHE_EN
                    addr_next = pc_addr;
`endif
                    if (hit) begin
                        state_next = DONE;
                        valid_next = 1'b1;
                        data_next  = hit_word;
                    end else begin
                        state_next = CMD;
                        cs_n_next  = 1'b0;
                        tx_next    = {READ_OP[6:0], byte_addr};
                        mosi_next  = READ_OP[7];
                        div_next   = 8'd0;
                        bit_next   = 6'd0;
                    end
                end
            end
            CMD, ADDR, DATA: begin
                if (div_cnt == DIV_LAST) begin
                    div_next = 8'd0;
                    if (!spi_sck) begin
                        sck_next = 1'b1;
                        if (state == DATA) begin
                            rx_next = {rx[14:0], spi_miso};
                        end
                    end else begin
                        sck_next = 1'b0;
                        if (bit_cnt == 6'd47) begin
                            state_next = DONE;
                            cs_n_next  = 1'b1;
                            mosi_next  = 1'b0;
                            valid_next = 1'b1;
                            data_next  = rx;
                        end else begin
                            bit_next  = bit_cnt + 6'd1;
                            mosi_next = tx[30];
                            tx_next   = {tx[29:0], 1'b0};
                            if (bit_cnt == 6'd7) begin
                                state_next = ADDR;
                            end else if (bit_cnt == 6'd31) begin
                                state_next = DATA;
                            end
                        end
                    end
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            DONE: begin
                state_next = GAP;
                busy_next  = 1'b0;
                gap_next   = 1'b0;
                cs_n_next  = 1'b1;
            end
            GAP: begin
                if (gap_cnt) begin
                    state_next = IDLE;
                end else begin
                    gap_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= '0;
            rx         <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= 1'b0;
            spi_sck    <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_mosi   <= 1'b0;
            flash_data <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            tx         <= tx_next;
            rx         <= rx_next;
            div_cnt    <= div_next;
            bit_cnt    <= bit_next;
            gap_cnt    <= gap_next;
            spi_sck    <= sck_next;
            spi_cs_n   <= cs_n_next;
            spi_mosi   <= mosi_next;
            flash_data <= data_next;
            data_valid <= valid_next;
            busy       <= busy_next;
        end
    end

`ifdef FETCH_CACHE_EN
    // cache entry refreshed with the delivered word on every DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            req_addr    <= '0;
        end else begin
            req_addr <= addr_next;
            if (state == DONE) begin
                cache_valid <= 1'b1;
                cache_tag   <= req_addr;
                cache_word  <= flash_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_flash_fetch_unit.sv
// Scoreboard bench for flash_fetch_unit with a behavioural SPI flash.
// Expected words/addresses come from a byte-pattern flash model.
module tb_flash_fetch_unit;

    localparam int CD  = 2;
    localparam int LAT = 1 + 96 * CD;
`ifdef FETCH_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pc_addr = '0;
    logic        fetch_req = 1'b0;
    logic [15:0] flash_data;
    logic        data_valid, busy, spi_cs_n, spi_sck, spi_mosi;
    logic        spi_miso = 1'b0;

    logic [11:0] pc2 = '0;
    logic        req2 = 1'b0;
    logic [15:0] flash_data2;
    logic        dv2, busy2, cs2, sck2, mosi2;
    logic        miso2 = 1'b1;

    flash_fetch_unit #(.CLK_DIV(CD), .BASE_ADDR(24'h000000)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .fetch_req(fetch_req),
        .flash_data(flash_data), .data_valid(data_valid), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    flash_fetch_unit #(.CLK_DIV(1), .BASE_ADDR(24'hFFFFF0)) dut_wrap (
        .clk(clk), .rst(rst), .pc_addr(pc2), .fetch_req(req2),
        .flash_data(flash_data2), .data_valid(dv2), .busy(busy2),
        .spi_cs_n(cs2), .spi_sck(sck2), .spi_mosi(mosi2),
        .spi_miso(miso2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    // cycle counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] pc;
        logic [15:0] data;
        logic [31:0] cmd;
        int          acc;
        bit          hit;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   dv_cnt = 0;
    int   n_falls = 0;
    int   cs_fall_cyc = -1;
    int   hi_run = 0;
    int   exp_dv = 0;
    int   spi_bad = 0;
    bit   prev_dv = 1'b0;
    bit   prev_cs = 1'b1;
    bit          m_valid = 1'b0;
    logic [11:0] m_tag = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fb(input logic [23:0] a);
        logic [7:0] v;
        if (a == 24'h00000A)      v = 8'hA5;
        else if (a == 24'h00000B) v = 8'h3C;
        else v = 8'(a[7:0] * 8'd29) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        return v;
    endfunction

    function automatic logic [23:0] baddr(input logic [23:0] base,
                                          input logic [11:0] pc);
        return 24'(base + 24'(pc) * 2);
    endfunction

    function automatic bit pred_hit(input logic [11:0] pc);
        return CACHE_ON && m_valid && (m_tag == pc);
    endfunction

    function automatic exp_t make_exp(input logic [11:0] pc, input int acc);
        exp_t e;
        logic [23:0] a;
        a = baddr(24'h000000, pc);
        e.pc   = pc;
        e.cmd  = {8'h03, a};
        e.data = {fb(a), fb(a + 24'd1)};
        e.acc  = acc;
        e.hit  = pred_hit(pc);
        return e;
    endfunction

    // behavioural SPI flash: mode 0, shifts data out on SCK falling edges
    int          sl_cnt = 0;
    logic [31:0] sl_sh = '0;
    logic [31:0] sl_cap = '0;
    logic [15:0] sl_word = '0;
    bit          sl_sck_d = 1'b0;
    always @(negedge clk) begin
        if (spi_cs_n !== 1'b0) begin
            sl_cnt = 0;
            if (spi_sck !== 1'b0 || spi_mosi !== 1'b0) spi_bad++;
        end else begin
            if (spi_sck && !sl_sck_d) begin
                if (sl_cnt >= 32 && spi_mosi !== 1'b0) spi_bad++;
                sl_sh = {sl_sh[30:0], spi_mosi};
                sl_cnt++;
                if (sl_cnt == 32) begin
                    sl_cap  = sl_sh;
                    sl_word = {fb(sl_sh[23:0]), fb(sl_sh[23:0] + 24'd1)};
                end
            end
            if (!spi_sck && sl_sck_d && sl_cnt >= 32 && sl_cnt < 48)
                spi_miso = sl_word[15 - (sl_cnt - 32)];
        end
        sl_sck_d = spi_sck;
    end

    // capture of the MOSI stream of the wrapping-address instance
    logic [47:0] sh2 = '0;
    bit          sck2_d = 1'b0;
    always @(negedge clk) begin
        if (cs2 === 1'b0 && sck2 && !sck2_d) sh2 = {sh2[46:0], mosi2};
        sck2_d = sck2;
    end

    // monitor: pops the scoreboard on every data_valid pulse
    exp_t mon_e;
    int   mon_acc;
    always @(negedge clk) begin
        if (spi_cs_n === 1'b0 && prev_cs) begin
            cs_fall_cyc = cyc - 1;
            n_falls++;
            chk("cs_high_gap_ge2", 64'(hi_run >= 2), 1);
        end
        hi_run = (spi_cs_n === 1'b1) ? hi_run + 1 : 0;
        if (data_valid === 1'b1) begin
            dv_cnt++;
            chk("dv_one_cycle", prev_dv, 0);
            chk("busy_at_dv", busy, 1);
            chk("dv_expected", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                mon_acc = (mon_e.acc >= 0) ? mon_e.acc : cs_fall_cyc;
                chk("latency", 64'(cyc - mon_acc), mon_e.hit ? 1 : LAT);
                chk("flash_data", flash_data, mon_e.data);
                if (mon_e.hit)
                    chk("hit_no_spi", 64'(cs_fall_cyc < mon_e.acc), 1);
                else
                    chk("cmd_addr", sl_cap, mon_e.cmd);
            end
        end
        prev_dv = (data_valid === 1'b1);
        prev_cs = (spi_cs_n !== 1'b0);
    end

    task automatic issue(input logic [11:0] pc, input bit hold,
                         input logic [11:0] pc_after);
        sb.push_back(make_exp(pc, cyc));
        m_valid = 1'b1;
        m_tag   = pc;
        fetch_req = 1'b1;
        pc_addr   = pc;
        exp_dv++;
        @(negedge clk);
        pc_addr = pc_after;
        if (!hold) fetch_req = 1'b0;
    endtask

    task automatic wait_dv(input int n);
        int t = 0;
        while (dv_cnt < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("dv_arrived", 64'(dv_cnt >= n), 1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi_dv_busy_data",
            {spi_mosi, data_valid, busy, flash_data}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int t;
        int a;
        bit hold;
        logic [11:0] pc, last_pc;

        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_reset_outs();
        end

        // first request on the first cycle out of reset
        rst = 1'b0;
        issue(12'h005, 1'b0, 12'h000);
        wait_dv(exp_dv);

        // request glitch: drop req and move pc right after acceptance
        repeat (4) @(negedge clk);
        f0 = n_falls;
        issue(12'h001, 1'b0, 12'h7FF);
        wait_dv(exp_dv);
        repeat (300) @(negedge clk);
        chk("glitch_one_dv", dv_cnt, exp_dv);
        chk("glitch_one_txn", n_falls - f0, 1);

        // reset in the middle of a transaction
        repeat (4) @(negedge clk);
        issue(12'h123, 1'b0, 12'h123);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        exp_dv--;
        m_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_reset_outs();
        end
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_no_dv", dv_cnt, exp_dv);
        chk("abort_data", flash_data, 0);

        // back-to-back requests with req held high
        f0 = n_falls;
        sb.push_back(make_exp(12'h000, cyc));
        m_valid = 1'b1;
        m_tag = 12'h000;
        fetch_req = 1'b1;
        pc_addr = 12'h000;
        @(negedge clk);
        pc_addr = 12'h001;
        sb.push_back(make_exp(12'h001, -1));
        m_tag = 12'h001;
        exp_dv += 2;
        wait_dv(exp_dv - 1);
        t = 0;
        while (spi_cs_n !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        fetch_req = 1'b0;
        chk("b2b_second_start", spi_cs_n, 0);
        wait_dv(exp_dv);
        chk("b2b_two_txn", n_falls - f0, 2);

        // repeated fetch (cache hit when enabled), then reset clears it
        repeat (4) @(negedge clk);
        issue(12'h020, 1'b0, 12'h020);
        wait_dv(exp_dv);
        repeat (4) @(negedge clk);
        issue(12'h020, 1'b0, 12'h3AB);
        wait_dv(exp_dv);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        f0 = n_falls;
        issue(12'h020, 1'b0, 12'h020);
        wait_dv(exp_dv);
        chk("after_rst_full_txn", n_falls - f0, 1);

        // randomized fetches with occasional repeats
        last_pc = 12'h020;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(4, 8)) @(negedge clk);
            pc = ($urandom_range(0, 2) == 0) ? last_pc : 12'($urandom);
            hold = 1'($urandom_range(0, 1));
            issue(pc, hold, hold ? pc : 12'($urandom));
            wait_dv(exp_dv);
            fetch_req = 1'b0;
            last_pc = pc;
        end

        // address wrap on the second instance (CLK_DIV=1)
        repeat (4) @(negedge clk);
        req2 = 1'b1;
        pc2 = 12'h010;
        a = cyc;
        @(negedge clk);
        req2 = 1'b0;
        t = 0;
        while (dv2 !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("wrap_dv", dv2, 1);
        chk("wrap_latency", 64'(cyc - a), 97);
        chk("wrap_cmd_addr", sh2[47:16], {8'h03, 24'h000010});
        chk("wrap_data", flash_data2, 16'hFFFF);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 0);
        chk("dv_total", dv_cnt, exp_dv);
        chk("spi_pin_rules", spi_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
